shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-pass shift controller around one shared 32-bit logical right shifter (srl).
//  Accepts SRL/SLL/SRA/ROR/ROL requests over valid/ready and issues at most two shifter passes per request.
//  Bit-reversal, fill masks and OR-combining are all sequenced here, so the datapath needs only one srl instance.
//  Sits between ALU decode and the writeback mux as the ALU's shift execution unit.
// PARAMETERS
//  ZERO_SKIP  1  1: ROR/ROL with shamt==0 completes in one pass; 0: always two passes
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   unit can accept; high iff state==IDLE
//  req_op     in   3   0 SRL, 1 SLL, 2 SRA, 3 ROR, 4 ROL, 5-7 reserved
//  req_data   in   32  operand
//  req_shamt  in   5   shift amount 0..31
//  rsp_valid  out  1   result valid, held until accepted
//  rsp_ready  in   1   consumer accepts result
//  rsp_data   out  32  result
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, rsp_valid=0, rsp_data=0, busy=0, op/data/shamt/acc regs=0.
//   req_ready=1 in IDLE, including while rst_n is low.
//  FSM states: IDLE, P1, P2, DONE.
//  IDLE: on req_valid&&req_ready, capture op/data/shamt -> P1.
//  P1: one srl pass, result into acc.
//   SRL: srl(d,n).  SLL: rev(srl(rev(d),n)).  SRA: srl(d,n).  ROR: srl(d,n).
//   ROL: srl(d,(-n)&31), i.e. ROR by (32-n) mod 32.  Reserved op: result=d.
//   Next state: P2 for SRA, and for ROR/ROL unless (ZERO_SKIP && effective shamt==0). Otherwise DONE.
//  P2 (second pass):
//   SRA: acc | (d[31] ? ~srl(32'hFFFFFFFF,n) : 0).
//   ROR/ROL: acc | rev(srl(rev(d),(-m)&31)), where m is the effective right-rotate amount.
//   When m==0 with ZERO_SKIP=0, the P2 term equals d; result = d.
//   -> DONE.
//  DONE: rsp_valid=1, rsp_data=acc. On rsp_ready, go to IDLE and drop rsp_valid.
//   No new request is accepted in the same cycle (no bypass).
//  Latency, accept edge to rsp_valid: 2 cycles for one-pass ops, 3 cycles for two-pass ops.
//  Backpressure: rsp_data and rsp_valid are stable while rsp_ready=0.
//   req_valid is ignored outside IDLE.
//  Shifter inputs are muxed from registered state only; there is no combinational path from req_* to rsp_*.
//  Widths: shamt negation is 5-bit wrap. Fill mask is 32 bits. No carry or overflow output.
//  Reset mid-operation: abort immediately, no response emitted, next request handled normally.
// STRUCTURE
//  shift_defs.vh: OP_SRL..OP_ROL localparams, state encodings S_IDLE/S_P1/S_P2/S_DONE.
//  Sub-modules: one instance of existing srl, plus one new combinational bit_rev32 (instanced at srl input and output).
//  Everything else (FSM, operand muxes, acc) is in this module.
// TESTING
//  1 SRL d=0x80000000 n=31 -> 0x00000001; rsp_valid 2 cycles after accept.
//  2 SLL d=0x00000001 n=4 -> 0x00000010.
//    SLL d=0xFFFFFFFF n=31 -> 0x80000000.
//  3 SRA d=0xF0000000 n=4 -> 0xFF000000, 3-cycle latency.
//    SRA d=0x70000000 n=4 -> 0x07000000.
//    SRA d=0x80000000 n=0 -> 0x80000000.
//  4 ROR d=0x00000001 n=1 -> 0x80000000.
//    ROL d=0x80000001 n=4 -> 0x00000018.
//    ROR d=0x12345678 n=0 -> 0x12345678, 2-cycle latency with ZERO_SKIP=1.
//  5 Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_data constant, req_ready=0, no second capture.
//    Release -> IDLE, next request accepted 1 cycle later.
//  6 Assert rst_n=0 during P2 of an SRA -> rsp_valid=0 and busy=0 immediately.
//    After release: SRL 0x10 n=4 -> 0x1.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-pass shift sequencer: opcodes, FSM states, helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package shift_sequencer_pkg;

    localparam logic [2:0] OP_SRL = 3'd0;
    localparam logic [2:0] OP_SLL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_P1   = 2'd1,
        S_P2   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // 5-bit two's-complement negation; wraps so that neg5(0) == 0.
    function automatic logic [4:0] neg5(input logic [4:0] n);
        return 5'd0 - n;
    endfunction

endpackage

// File: rtl/shift_sequencer_bit_rev32.sv
// 32-bit bit reversal (bit i of the output is bit 31-i of the input).
// Latency: combinational.
// Backpressure: none.
// Ports: i_data operand, o_data reversed operand.
module shift_sequencer_bit_rev32 (
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < 32; i++) begin
            o_data[i] = i_data[31-i];
        end
    end

endmodule

// File: rtl/shift_sequencer_srl.sv
// Shared 32-bit logical right shifter.
// Latency: combinational.
// Backpressure: none.
// Ports: i_data operand, i_shamt shift amount, o_data = i_data >> i_shamt.
module shift_sequencer_srl (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_data
);

    assign o_data = i_data >> i_shamt;

endmodule

// File: rtl/shift_sequencer.sv
// Shift execution unit: SRL/SLL/SRA/ROR/ROL built from one logical right shifter in up to two passes.
// Latency: accept edge to rsp_valid is 2 cycles (one pass) or 3 cycles (two passes).
// Backpressure: one request in flight; req_ready only in IDLE; rsp held stable until rsp_ready.
// Ports: req_valid/req_ready/req_op/req_data/req_shamt in, rsp_valid/rsp_ready/rsp_data out, busy.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_data,
    input  logic [4:0]  req_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    state_e      r_state;
    logic [2:0]  r_op;
    logic [31:0] r_data;
    logic [4:0]  r_shamt;
    logic [31:0] r_acc;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;

    logic [31:0] w_data_rev;
    logic [31:0] w_srl_in;
    logic [4:0]  w_srl_amt;
    logic [31:0] w_srl_out;
    logic [31:0] w_srl_out_rev;
    logic [4:0]  w_m;
    logic [31:0] w_p1_res;
    logic [31:0] w_p2_res;
    logic        w_two_pass;

    shift_sequencer_bit_rev32 u_rev_in (
        .i_data (r_data),
        .o_data (w_data_rev)
    );

    shift_sequencer_srl u_srl (
        .i_data  (w_srl_in),
        .i_shamt (w_srl_amt),
        .o_data  (w_srl_out)
    );

    shift_sequencer_bit_rev32 u_rev_out (
        .i_data (w_srl_out),
        .o_data (w_srl_out_rev)
    );

    // Effective right-rotate amount: ROL by n is ROR by (32-n) mod 32.
    assign w_m = (r_op == OP_ROL) ? neg5(r_shamt) : r_shamt;

    // A rotate by zero is the identity, so it can skip the wrap-around pass.
    assign w_two_pass = (r_op == OP_SRA) ||
                        (((r_op == OP_ROR) || (r_op == OP_ROL)) &&
                         !(ZERO_SKIP && (w_m == 5'd0)));

    // Shifter operand muxes, driven from registered state only.
    always_comb begin
        w_srl_in  = r_data;
        w_srl_amt = r_shamt;
        w_p1_res  = w_srl_out;
        w_p2_res  = r_acc;
        if (r_state == S_P2) begin
            if (r_op == OP_SRA) begin
                // Sign fill: ~(all-ones >> n) sets the top n bits.
                w_srl_in  = 32'hFFFF_FFFF;
                w_srl_amt = r_shamt;
                w_p2_res  = r_acc | (r_data[31] ? ~w_srl_out : 32'h0);
            end else begin
                // Wrap-around bits of the rotate are a left shift by (32-m),
                // done as a reversed right shift. For m==0 this yields r_data.
                w_srl_in  = w_data_rev;
                w_srl_amt = neg5(w_m);
                w_p2_res  = r_acc | w_srl_out_rev;
            end
        end else begin
            case (r_op)
                OP_SRL, OP_SRA, OP_ROR: begin
                    w_srl_in  = r_data;
                    w_srl_amt = r_shamt;
                    w_p1_res  = w_srl_out;
                end
                OP_SLL: begin
                    w_srl_in  = w_data_rev;
                    w_srl_amt = r_shamt;
                    w_p1_res  = w_srl_out_rev;
                end
                OP_ROL: begin
                    w_srl_in  = r_data;
                    w_srl_amt = w_m;
                    w_p1_res  = w_srl_out;
                end
                default: begin
                    w_p1_res  = r_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_data      <= '0;
            r_shamt     <= '0;
            r_acc       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_data  <= req_data;
                        r_shamt <= req_shamt;
                        r_state <= S_P1;
                    end
                end
                S_P1: begin
                    r_acc   <= w_p1_res;
                    r_state <= w_two_pass ? S_P2 : S_DONE;
                end
                S_P2: begin
                    r_acc   <= w_p2_res;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // Present the result one cycle after entering DONE, then
                    // hold it until the consumer takes it.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_acc;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases plus random requests vs. an arithmetic model.
// Latency: checks 2/3-cycle accept-to-response timing.
// Backpressure: checks response hold under rsp_ready=0 and reset abort.
module tb_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_data;
    logic [4:0]  req_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    shift_sequencer #(.ZERO_SKIP(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: shifts and rotates from their arithmetic definitions.
    function automatic logic [31:0] rotr(input logic [31:0] d, input int n);
        logic [63:0] dd;
        dd = {d, d} >> n;
        return dd[31:0];
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] d, input logic [4:0] n);
        logic signed [31:0] s;
        int k;
        k = int'(n);
        s = d;
        case (op)
            3'd0:    return d >> k;
            3'd1:    return d << k;
            3'd2:    return s >>> k;
            3'd3:    return rotr(d, k);
            3'd4:    return rotr(d, (32 - k) % 32);
            default: return d;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [4:0] n);
        if (op == 3'd2) return 3;
        if ((op == 3'd3 || op == 3'd4) && n != 5'd0) return 3;
        return 2;
    endfunction

    // Present a request, wait for its response, check value and latency, then consume it.
    task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] d,
                           input logic [4:0] n, input bit check_lat);
        int cyc;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        if (!req_ready) chk({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_data = d; req_shamt = n;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data  = $urandom;
        req_shamt = 5'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        if (check_lat) chk({tag, "_lat"}, 32'(cyc), 32'(model_lat(op, n)));
        chk({tag, "_data"}, rsp_data, model(op, d, n));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int cyc;
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_data = '0; req_shamt = '0; rsp_ready = 1'b0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rsp_data",  rsp_data,       32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases.
        run_req("srl31",   3'd0, 32'h8000_0000, 5'd31, 1'b1);
        run_req("sll4",    3'd1, 32'h0000_0001, 5'd4,  1'b1);
        run_req("sll31",   3'd1, 32'hFFFF_FFFF, 5'd31, 1'b1);
        run_req("sra_neg", 3'd2, 32'hF000_0000, 5'd4,  1'b1);
        run_req("sra_pos", 3'd2, 32'h7000_0000, 5'd4,  1'b1);
        run_req("sra0",    3'd2, 32'h8000_0000, 5'd0,  1'b1);
        run_req("ror1",    3'd3, 32'h0000_0001, 5'd1,  1'b1);
        run_req("rol4",    3'd4, 32'h8000_0001, 5'd4,  1'b1);
        run_req("ror0",    3'd3, 32'h1234_5678, 5'd0,  1'b1);
        run_req("rol0",    3'd4, 32'hDEAD_BEEF, 5'd0,  1'b1);
        run_req("resv",    3'd6, 32'hCAFE_F00D, 5'd9,  1'b1);

        // Backpressure: response must hold, and a waiting request must not be captured.
        req_valid = 1'b1; req_op = 3'd1; req_data = 32'h0000_00FF; req_shamt = 5'd8;
        @(posedge clk); #1;
        req_op = 3'd0; req_data = 32'h0000_00F0; req_shamt = 5'd4;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        held = rsp_data;
        chk("bp_first", held, 32'h0000_FF00);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_data",  rsp_data,         held);
            chk("bp_hold_valid", 32'(rsp_valid),   32'd1);
            chk("bp_req_ready",  32'(req_ready),   32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_next_accept", 32'(busy), 32'd1);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk("bp_next_lat",  32'(cyc), 32'd2);
        chk("bp_next_data", rsp_data, 32'h0000_000F);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during P2 of an SRA aborts without a response.
        req_valid = 1'b1; req_op = 3'd2; req_data = 32'h8000_0000; req_shamt = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_busy",      32'(busy),      32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_req("post_rst", 3'd0, 32'h0000_0010, 5'd4, 1'b1);

        // Random requests, with occasional consumer stalls.
        for (int t = 0; t < 200; t++) begin
            logic [2:0]  op;
            logic [31:0] d;
            logic [4:0]  n;
            op = 3'($urandom_range(0, 7));
            d  = $urandom;
            n  = 5'($urandom_range(0, 31));
            if (t % 16 == 0) n = 5'd0;
            if (t % 4 == 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            run_req("rand", op, d, n, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
